ex_div: RTL and testbench

- Multi-cycle radix-2 restoring divider in the EX stage, serving DIV/DIVU.
- Consumes the operands and ALU op latched by the ID/EX pipeline register.
- Returns the quotient and remainder, for writing into LO and HI.
- Signals busy/ready so EX can raise a pipeline stall request back toward ID/IF while a division is in flight.

---
 rtl/ex_div_if.sv | 23 ++
 rtl/ex_div.sv | 129 ++++++++++++
 tb/tb_ex_div.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Operand/result bundle between the EX stage and the multi-cycle divider.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient} for HI/LO.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  div_if
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 neg1_q, neg1_d;
  logic                 neg2_q, neg2_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 neg1_in, neg2_in;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    neg1_in  = div_if.signed_div_i & div_if.opdata1_i[WIDTH-1];
    neg2_in  = div_if.signed_div_i & div_if.opdata2_i[WIDTH-1];
    abs1     = neg1_in ? -div_if.opdata1_i : div_if.opdata1_i;
    abs2     = neg2_in ? -div_if.opdata2_i : div_if.opdata2_i;
    // Shifted upper remainder keeps the bit that leaves the top, hence WIDTH+1 bits.
    trial    = rem_q[2*WIDTH-1:WIDTH-1];
    quot_fix = (neg1_q ^ neg2_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    rem_fix  = neg1_q ? -rem_q[2*WIDTH-1:WIDTH] : rem_q[2*WIDTH-1:WIDTH];

    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (div_if.start_i && !div_if.annul_i) begin
          if (div_if.opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d   = ON;
            rem_d     = {{WIDTH{1'b0}}, abs1};
            divisor_d = abs2;
            neg1_d    = neg1_in;
            neg2_d    = neg2_in;
            cnt_d     = '0;
          end
        end
      end
      BYZERO: begin
        state_d  = END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      ON: begin
        if (div_if.annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CNT_DONE) begin
          if (trial >= {1'b0, divisor_q}) begin
            rem_d = {trial[WIDTH-1:0] - divisor_q, rem_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[2*WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        // Annul is ignored here: EX has already taken the result.
        if (!div_if.start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
  assign div_if.busy_o   = (state_q == BYZERO) || (state_q == ON);
endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed/unsigned results, annul, reset, held start.
module tb_ex_div;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ex_div_if #(.WIDTH(32)) div_if ();

  ex_div #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a division and counts edges until ready; operands are scrambled after the sampling edge.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic busy_ok);
    edges   = 0;
    busy_ok = 1'b1;
    div_if.signed_div_i = sd;
    div_if.opdata1_i    = a;
    div_if.opdata2_i    = b;
    div_if.start_i      = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        div_if.opdata1_i    = 32'hDEAD_BEEF;
        div_if.opdata2_i    = 32'h0;
        div_if.signed_div_i = ~sd;
      end
      if (div_if.ready_o === 1'b1) break;
      if (div_if.busy_o !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic drop_start();
    div_if.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div_if.start_i      = 1'b0;
    div_if.annul_i      = 1'b0;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i    = '0;
    div_if.opdata2_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({div_if.ready_o, div_if.busy_o, div_if.result_o} !== 66'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got ready=%b busy=%b result=%h, expected all zero",
               div_if.ready_o, div_if.busy_o, div_if.result_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int   edges;
    logic busy_ok;
    run_div(1'b0, 32'd100, 32'd7, edges, busy_ok);
    tests_run++;
    if (edges !== 34) begin
      tests_failed++;
      $display("[TB] FAIL u100_7_latency: got %0d edges, expected 34", edges);
    end
    tests_run++;
    if (busy_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL u100_7_busy: busy dropped before ready, expected busy held");
    end
    tests_run++;
    if (div_if.result_o !== {32'd2, 32'd14}) begin
      tests_failed++;
      $display("[TB] FAIL u100_7_result: got %h, expected %h", div_if.result_o, {32'd2, 32'd14});
    end
    tests_run++;
    if (div_if.busy_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL u100_7_end_busy: got %b, expected 0", div_if.busy_o);
    end
    drop_start();
    tests_run++;
    if ({div_if.ready_o, div_if.result_o} !== 65'd0) begin
      tests_failed++;
      $display("[TB] FAIL u100_7_release: got ready=%b result=%h, expected 0/0",
               div_if.ready_o, div_if.result_o);
    end
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, edges, busy_ok);
    tests_run++;
    if (div_if.result_o !== {32'd1, 32'h7FFF_FFFC}) begin
      tests_failed++;
      $display("[TB] FAIL u_big_result: got %h, expected %h", div_if.result_o, {32'd1, 32'h7FFF_FFFC});
    end
    drop_start();
  endtask

  task automatic test_signed();
    int   edges;
    logic busy_ok;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, edges, busy_ok);
    tests_run++;
    if (div_if.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      tests_failed++;
      $display("[TB] FAIL s_m7_2: got %h, expected %h", div_if.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    drop_start();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, edges, busy_ok);
    tests_run++;
    if (div_if.result_o !== {32'd1, 32'hFFFF_FFFD}) begin
      tests_failed++;
      $display("[TB] FAIL s_7_m2: got %h, expected %h", div_if.result_o, {32'd1, 32'hFFFF_FFFD});
    end
    drop_start();
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, edges, busy_ok);
    tests_run++;
    if (div_if.result_o !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
      tests_failed++;
      $display("[TB] FAIL s_m100_7: got %h, expected %h", div_if.result_o, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    end
    drop_start();
  endtask

  task automatic test_div_zero();
    int   edges;
    logic busy_ok;
    run_div(1'b0, 32'h1234, 32'd0, edges, busy_ok);
    tests_run++;
    if (edges !== 2) begin
      tests_failed++;
      $display("[TB] FAIL divzero_latency: got %0d edges, expected 2", edges);
    end
    tests_run++;
    if (busy_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL divzero_busy: busy low in BYZERO, expected 1");
    end
    tests_run++;
    if ({div_if.result_o, div_if.busy_o} !== 65'd0) begin
      tests_failed++;
      $display("[TB] FAIL divzero_result: got result=%h busy=%b, expected 0/0",
               div_if.result_o, div_if.busy_o);
    end
    drop_start();
  endtask

  task automatic test_annul();
    int   edges;
    logic busy_ok;
    logic saw_ready;
    saw_ready = 1'b0;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i    = 32'd100;
    div_if.opdata2_i    = 32'd7;
    div_if.start_i      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (div_if.ready_o === 1'b1) saw_ready = 1'b1;
    end
    div_if.annul_i = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (div_if.busy_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL annul_free: got busy=%b, expected 0", div_if.busy_o);
    end
    // Start and annul together in FREE must not be accepted.
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_if.ready_o === 1'b1 || div_if.busy_o === 1'b1) saw_ready = 1'b1;
    end
    tests_run++;
    if (saw_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL annul_no_ready: got activity=%b, expected 0", saw_ready);
    end
    div_if.annul_i = 1'b0;
    div_if.start_i = 1'b0;
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd9, 32'd3, edges, busy_ok);
    tests_run++;
    if (edges !== 34 || div_if.result_o !== {32'd0, 32'd3}) begin
      tests_failed++;
      $display("[TB] FAIL annul_restart: got %0d edges result=%h, expected 34 edges %h",
               edges, div_if.result_o, {32'd0, 32'd3});
    end
    drop_start();
  endtask

  task automatic test_reset_mid();
    int   edges;
    logic busy_ok;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i    = 32'd100;
    div_if.opdata2_i    = 32'd7;
    div_if.start_i      = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    div_if.start_i = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({div_if.ready_o, div_if.busy_o, div_if.result_o} !== 66'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got ready=%b busy=%b result=%h, expected all zero",
               div_if.ready_o, div_if.busy_o, div_if.result_o);
    end
    rst = 1'b0;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_ok);
    tests_run++;
    if (edges !== 34 || div_if.result_o !== {32'd0, 32'h8000_0000}) begin
      tests_failed++;
      $display("[TB] FAIL overflow: got %0d edges result=%h, expected 34 edges %h",
               edges, div_if.result_o, {32'd0, 32'h8000_0000});
    end
  endtask

  task automatic test_back_to_back();
    int   edges;
    logic busy_ok;
    logic held_ok;
    held_ok = 1'b1;
    // Start is still high from the overflow division; operands change to prove nothing restarts.
    div_if.opdata1_i = 32'd50;
    div_if.opdata2_i = 32'd5;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (div_if.ready_o !== 1'b1 || div_if.busy_o !== 1'b0 ||
          div_if.result_o !== {32'd0, 32'h8000_0000}) held_ok = 1'b0;
    end
    tests_run++;
    if (held_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL held_start: got ready=%b busy=%b result=%h, expected 1/0/%h",
               div_if.ready_o, div_if.busy_o, div_if.result_o, {32'd0, 32'h8000_0000});
    end
    drop_start();
    run_div(1'b0, 32'd1000, 32'd10, edges, busy_ok);
    tests_run++;
    if (edges !== 34 || div_if.result_o !== {32'd0, 32'd100}) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: got %0d edges result=%h, expected 34 edges %h",
               edges, div_if.result_o, {32'd0, 32'd100});
    end
    drop_start();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
